// File: rtl/inmem_burst_port.sv
// Burst engine in front of one port of an inferred block RAM.
// Write bursts pass each accepted beat straight to the memory port; read bursts
// issue addresses under a credit limit so the RD_LAT+1 deep return FIFO can
// never overflow, whatever the consumer does with rd_ready.
module inmem_burst_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_we,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              done,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam int DEPTH = RD_LAT + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  cur_addr;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beat_cnt;
  logic [LEN_W-1:0]   pop_cnt;

  logic [RD_LAT-1:0]  rd_pipe;
  logic [OCC_W-1:0]   inflight;
  logic [OCC_W-1:0]   occ;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [DATA_W-1:0]  fifo_mem [DEPTH];

  logic               rd_issued;
  logic               push;
  logic               pop;
  logic               issue;
  logic [OCC_W:0]     used;
  logic [OCC_W:0]     limit;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == WRITE);
  assign rd_valid  = (occ != '0);
  assign rd_data   = fifo_mem[head];

  assign rd_issued = mem_en_o & ~mem_we_o;
  assign push      = rd_pipe[RD_LAT-1];
  assign pop       = rd_valid & rd_ready;

  // A beat popped this cycle frees its slot in time for a read issued now.
  assign used  = {1'b0, inflight} + {1'b0, occ};
  assign limit = (OCC_W+1)'(DEPTH) + {{OCC_W{1'b0}}, pop};
  assign issue = (state == READ) && (used < limit);

  // Read-return timing pipeline: the tap at RD_LAT-1 marks the cycle mem_data_i is valid.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_lat
      if (gi == 0) begin : g_first
        // First stage samples the cycle a read is presented to the memory.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) rd_pipe[gi] <= 1'b0;
          else     rd_pipe[gi] <= rd_issued;
        end
      end else begin : g_next
        // Later stages delay the marker one cycle each.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) rd_pipe[gi] <= 1'b0;
          else     rd_pipe[gi] <= rd_pipe[gi-1];
        end
      end
    end
  endgenerate

  // Credit and FIFO bookkeeping; reset also forgets any reads still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
      occ      <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= inflight + OCC_W'(issue) - OCC_W'(push);
      occ      <= occ + OCC_W'(push) - OCC_W'(pop);
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
    end
  end

  // Return FIFO storage, written only at the capture point.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[tail] <= mem_data_i;
  end

  // Burst sequencer with registered memory-port and done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
      pop_cnt    <= '0;
      done       <= 1'b0;
      mem_en_o   <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      done     <= 1'b0;
      mem_en_o <= 1'b0;
      mem_we_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cur_addr <= cmd_addr;
            len_q    <= cmd_len;
            beat_cnt <= '0;
            pop_cnt  <= '0;
            state    <= cmd_we ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            mem_en_o   <= 1'b1;
            mem_we_o   <= 1'b1;
            mem_addr_o <= cur_addr;
            mem_data_o <= wr_data;
            cur_addr   <= cur_addr + 1'b1;
            beat_cnt   <= beat_cnt + 1'b1;
            if (beat_cnt == len_q) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            mem_en_o   <= 1'b1;
            mem_addr_o <= cur_addr;
            cur_addr   <= cur_addr + 1'b1;
            beat_cnt   <= beat_cnt + 1'b1;
            if (beat_cnt == len_q) state <= DRAIN;
          end
          if (pop) pop_cnt <= pop_cnt + 1'b1;
        end
        DRAIN: begin
          if (pop) begin
            pop_cnt <= pop_cnt + 1'b1;
            if (pop_cnt == len_q) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
